// File: rtl/vga_timing_gen.sv
// Line-based VGA timing and pattern generator: h/v counters -> stage 1 (pix_req, x/y) -> stage 2 (syncs, de, RGB).
// pix_req/x/y lag the counters by 1 clk; syncs/de/pulses/RGB by 2 clk. Free-running, no backpressure.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit H_POL      = 1'b0,
   parameter bit V_POL      = 1'b0,
   parameter int COLOR_BITS = 4,
   parameter int BAR_SHIFT  = 6,
   parameter int CHK_SHIFT  = 5,
   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW        = $clog2(H_TOTAL),
   localparam int VW        = $clog2(V_TOTAL)
) (
   input  logic                    clk_60Mhz,
   input  logic                    reset_,
   input  logic                    i_en,
   input  logic [1:0]              i_mode,
   input  logic [3*COLOR_BITS-1:0] i_ext_rgb,
   output logic                    o_pix_req,
   output logic [HW-1:0]           o_x,
   output logic [VW-1:0]           o_y,
   output logic                    o_hsync,
   output logic                    o_vsync,
   output logic                    o_de,
   output logic [COLOR_BITS-1:0]   o_r,
   output logic [COLOR_BITS-1:0]   o_g,
   output logic [COLOR_BITS-1:0]   o_b,
   output logic                    o_frame_start,
   output logic                    o_line_start
);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [COLOR_BITS-1:0] ONES = {COLOR_BITS{1'b1}};

   logic [HW-1:0]         h_cnt_q, h_cnt_d;
   logic [VW-1:0]         v_cnt_q, v_cnt_d;
   logic [1:0]            mode_q, mode_d;
   logic                  pix_q, pix_d, hs1_q, hs1_d, vs1_q, vs1_d;
   logic [HW-1:0]         x_q, x_d;
   logic [VW-1:0]         y_q, y_d;
   logic                  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
   logic                  line_q, line_d, frame_q, frame_d;
   logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic [2:0]            bar_idx;
   logic                  chk_bit;

   assign bar_idx = 3'(x_q >> BAR_SHIFT);
   assign chk_bit = x_q[CHK_SHIFT] ^ y_q[CHK_SHIFT];

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!i_en) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
         h_cnt_d = h_cnt_q + 1'b1;
      end
      // Mode only changes at the top-left of a frame so a frame is never torn.
      mode_d = (h_cnt_q == '0 && v_cnt_q == '0) ? i_mode : mode_q;
   end

   always_comb begin
      pix_d = 1'b0;
      x_d   = '0;
      y_d   = '0;
      hs1_d = ~H_POL;
      vs1_d = ~V_POL;
      if (i_en) begin
         pix_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
         x_d   = pix_d ? h_cnt_q : x_q;
         y_d   = pix_d ? v_cnt_q : y_q;
         hs1_d = (h_cnt_q >= H_SS && h_cnt_q < H_SE) ? H_POL : ~H_POL;
         vs1_d = (v_cnt_q >= V_SS && v_cnt_q < V_SE) ? V_POL : ~V_POL;
      end
   end

   always_comb begin
      hsync_d = hs1_q;
      vsync_d = vs1_q;
      de_d    = pix_q;
      line_d  = pix_q && (x_q == '0);
      frame_d = pix_q && (x_q == '0) && (y_q == '0);
      r_d     = '0;
      g_d     = '0;
      b_d     = '0;
      if (pix_q) begin
         case (mode_q)
            2'd1: begin
               r_d = bar_idx[0] ? ONES : '0;
               g_d = bar_idx[1] ? ONES : '0;
               b_d = bar_idx[2] ? ONES : '0;
            end
            2'd2: begin
               r_d = chk_bit ? ONES : '0;
               g_d = chk_bit ? ONES : '0;
               b_d = chk_bit ? ONES : '0;
            end
            2'd3:    {r_d, g_d, b_d} = i_ext_rgb;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_60Mhz or negedge reset_) begin
      if (!reset_) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         mode_q  <= '0;
         pix_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         hs1_q   <= ~H_POL;
         vs1_q   <= ~V_POL;
         hsync_q <= ~H_POL;
         vsync_q <= ~V_POL;
         de_q    <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         mode_q  <= mode_d;
         pix_q   <= pix_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hs1_q   <= hs1_d;
         vs1_q   <= vs1_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         line_q  <= line_d;
         frame_q <= frame_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
      end
   end

   assign o_pix_req     = pix_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_hsync       = hsync_q;
   assign o_vsync       = vsync_q;
   assign o_de          = de_q;
   assign o_line_start  = line_q;
   assign o_frame_start = frame_q;
   assign o_r           = r_q;
   assign o_g           = g_q;
   assign o_b           = b_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing and pattern generator, successor to the fixed-timing 60 MHz driver. It is line-based: the vertical counter advances once per line, not per clock. It drives programmable sync polarity, a data-enable, and pixel coordinates, plus multi-bit RGB from a built-in pattern or an external pixel source. It sits at the top of the display path and feeds the board VGA DAC/resistor ladder.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
COLOR_BITS, 4, bits per colour channel
BAR_SHIFT, 6, colour-bar index = x >> BAR_SHIFT (low 3 bits)
CHK_SHIFT, 5, checker bit position in x and y
Derived: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*. Counter widths = clog2(total).

Ports:
clk_60Mhz  input  1  pixel clock
reset_  input  1  asynchronous, active-low reset
i_en  input  1  run enable
i_mode  input  2  0 blank, 1 colour bars, 2 checker, 3 external
i_ext_rgb  input  3*COLOR_BITS  external pixel {r,g,b}, sampled when o_pix_req=1
o_pix_req  output  1  external pixel request (valid coordinates on o_x/o_y)
o_x  output  clog2(H_TOTAL)  pixel column for o_pix_req
o_y  output  clog2(V_TOTAL)  pixel line for o_pix_req
o_hsync  output  1  horizontal sync
o_vsync  output  1  vertical sync
o_de  output  1  data enable (visible region)
o_r, o_g, o_b  output  COLOR_BITS each  colour
o_frame_start  output  1  one-clock pulse aligned with first visible pixel of a frame
o_line_start  output  1  one-clock pulse aligned with first visible pixel of each visible line

Behaviour:
- Reset (async assert, sync release): h_cnt = v_cnt = 0. Syncs at inactive level (~H_POL, ~V_POL). o_de, o_pix_req, o_frame_start, o_line_start, RGB, o_x, o_y = 0. Mode shadow = 0.
- Line order: active, front porch, sync, back porch. Same order for frames.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments only on h_cnt wrap, counts 0..V_TOTAL-1, and wraps.
- i_en=0: counters forced to 0 on the next clock. Stage registers flush to reset values one clock per stage. i_en=1 from idle starts at h=v=0, i.e. a frame start.
- Stage 1 (1 clk after counters): o_pix_req = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE). o_x/o_y = counters when o_pix_req=1, else hold last value.
- Stage 2 (2 clk after counters): o_hsync = H_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~H_POL; o_vsync likewise on v_cnt. o_de = delayed o_pix_req. o_line_start = o_de && x==0. o_frame_start = o_de && x==0 && y==0. Syncs and de stay mutually aligned for any parameter set.
- RGB: all zero whenever o_de=0.
  - Mode 1: idx = (x>>BAR_SHIFT)[2:0]; each channel all-ones if idx bit set (r=bit0, g=bit1, b=bit2), else 0.
  - Mode 2: all channels all-ones when x[CHK_SHIFT]^y[CHK_SHIFT], else 0.
  - Mode 3: i_ext_rgb sampled on the o_pix_req cycle, presented on the following (o_de) cycle.
  - Mode 0: all zero.
- i_mode is captured into the shadow register only when h_cnt==0 && v_cnt==0. A mid-frame change takes effect at the next frame start and never tears a frame.
- Reset mid-frame: outputs return to reset values asynchronously. No partial pulse on o_frame_start.

Test Plan:
- Small params H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), i_en=1 after reset → o_hsync low exactly for counter h=10..12 (output cycles +2). Period 16 clk. o_vsync low 32 clk per 128-clk frame, starting at line 5.
- Same params, mode 0 → o_de high 8 clk per line on lines 0..3 only. o_frame_start pulses once per 128 clk. o_line_start pulses 4 times per frame.
- Mode 1, BAR_SHIFT=0, small params → visible line RGB channel pattern r: 0,F,0,F,0,F,0,F; g: 0,0,F,F,…; b: 0000FFFF (COLOR_BITS=4).
- Mode 3, i_ext_rgb = {x,y-coded} driven combinationally from o_x/o_y → output pixel at o_de matches that coordinate's value, with one-clock offset to o_pix_req.
- Switch i_mode 1→2 mid-frame → current frame finishes as bars. Checker appears from the next o_frame_start.
- Toggle i_en low mid-line, then high → outputs idle within 2 clk. Restart produces sync/de identical to post-reset. Async reset_ pulse mid-frame → immediate reset values.
